// File: rtl/booth_prod_accum.sv
// Accumulates a programmed batch of signed Booth-multiplier products into a wider register.
// Optional macro BOOTH_ACC_SAT_EN: saturate instead of wrap on signed overflow.
module booth_prod_accum #(
    parameter int P_W   = 16,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             p_valid,
    input  logic [P_W-1:0]   p,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_lat;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] add_res;
    logic [CNT_W-1:0] cnt_nxt;
    logic             add_ovf;

    assign p_ext   = {{(ACC_W-P_W){p[P_W-1]}}, p};
    assign sum     = acc + p_ext;
    assign cnt_nxt = cnt + 1'b1;
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    always_comb begin
        add_res = sum;
        if (add_ovf)
            add_res = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign add_res = sum;
`endif

    // p_ready and busy are registered alongside the state so they decode from it only.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            n_lat     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            p_ready   <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ovf <= 1'b0;
                        if (num_terms != '0) begin
                            acc     <= '0;
                            cnt     <= '0;
                            n_lat   <= num_terms;
                            state   <= ACC;
                            p_ready <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            acc_out   <= '0;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (p_valid) begin
                        acc <= add_res;
                        cnt <= cnt_nxt;
                        if (add_ovf)
                            ovf <= 1'b1;
                        if (cnt_nxt == n_lat) begin
                            state   <= DONE;
                            p_ready <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    acc_out   <= acc;
                    acc_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    p_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
